hqm_rcfwl_gclk_rlink_sync_ctl: RTL

Controller for the global-clock repeater-link spine. It brings up the downstream rlink clock-distribution segments one at a time, once the PLL has held lock for a qualified interval, and drives their enables with a fixed stagger. It then emits the periodic pll_sync pulse carried down the rlink chain. It sits at the spine root, between the PLL lock/sync source and the first rlink clkdist stage.

---
 rtl/hqm_rcfwl_gclk_rlink_sync_ctl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hqm_rcfwl_gclk_rlink_sync_ctl.sv
// Global-clock repeater-link spine controller: qualifies PLL lock, staggers the
// rlink segment clock enables up and down, and issues the periodic pll_sync pulse.
`timescale 1ns/1ps
module hqm_rcfwl_gclk_rlink_sync_ctl #(
  parameter int NUM_SEG     = 4,
  parameter int STAGGER_CYC = 8,
  parameter int LOCK_CYC    = 16
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               req,
  input  logic               pll_lock,
  input  logic [7:0]         sync_period,
  output logic [NUM_SEG-1:0] seg_en,
  output logic               pll_sync_out,
  output logic               ack,
  output logic               busy,
  output logic               lock_err,
  output logic [15:0]        sync_cnt
);

  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam int SW = $clog2(STAGGER_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOCK_WAIT,
    RAMP_UP,
    RUN,
    RAMP_DOWN
  } state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic [SW-1:0]        stg_cnt_q, stg_cnt_d, stg_cnt_inc;
  logic [7:0]           per_cnt_q, per_cnt_d;
  logic [NUM_SEG-1:0]   seg_en_q, seg_en_d;
  logic                 sync_q, sync_d;
  logic                 ack_q, busy_q;
  logic                 lock_err_q, lock_err_d;
  logic [15:0]          sync_cnt_q, sync_cnt_d;
  logic                 stg_done;

  assign lock_cnt_inc = lock_cnt_q + 1'b1;
  assign stg_cnt_inc  = stg_cnt_q + 1'b1;
  assign stg_done     = (stg_cnt_inc == SW'(STAGGER_CYC));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    per_cnt_d  = per_cnt_q;
    seg_en_d   = seg_en_q;
    sync_d     = 1'b0;
    lock_err_d = lock_err_q;
    sync_cnt_d = sync_cnt_q;

    case (state_q)
      IDLE: begin
        seg_en_d = '0;
        if (req) begin
          state_d    = LOCK_WAIT;
          lock_cnt_d = '0;
          lock_err_d = 1'b0;
        end
      end

      LOCK_WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (!pll_lock) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_inc == LW'(LOCK_CYC)) begin
          state_d    = RAMP_UP;
          lock_cnt_d = '0;
          stg_cnt_d  = '0;
          seg_en_d   = NUM_SEG'(1);
        end else begin
          lock_cnt_d = lock_cnt_inc;
        end
      end

      RAMP_UP, RUN: begin
        // Abort and lock loss share one exit; ramp-down starts from the bits already on.
        if (!req || !pll_lock) begin
          state_d   = RAMP_DOWN;
          stg_cnt_d = '0;
          seg_en_d  = seg_en_q >> 1;
          if (!pll_lock) lock_err_d = 1'b1;
        end else if (state_q == RAMP_UP) begin
          if (stg_done) begin
            stg_cnt_d = '0;
            if (seg_en_q[NUM_SEG-1]) begin
              state_d    = RUN;
              sync_d     = 1'b1;
              per_cnt_d  = sync_period;
              sync_cnt_d = sync_cnt_q + 16'd1;
            end else begin
              seg_en_d = (seg_en_q << 1) | NUM_SEG'(1);
            end
          end else begin
            stg_cnt_d = stg_cnt_inc;
          end
        end else if (per_cnt_q == 8'd0) begin
          // Period is reloaded only at a pulse, so a new sync_period lands after it.
          sync_d     = 1'b1;
          per_cnt_d  = sync_period;
          sync_cnt_d = sync_cnt_q + 16'd1;
        end else begin
          per_cnt_d = per_cnt_q - 8'd1;
        end
      end

      RAMP_DOWN: begin
        if (seg_en_q == '0) begin
          state_d   = IDLE;
          stg_cnt_d = '0;
        end else if (stg_done) begin
          stg_cnt_d = '0;
          seg_en_d  = seg_en_q >> 1;
        end else begin
          stg_cnt_d = stg_cnt_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_b) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      stg_cnt_q  <= '0;
      per_cnt_q  <= '0;
      seg_en_q   <= '0;
      sync_q     <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      lock_err_q <= 1'b0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      per_cnt_q  <= per_cnt_d;
      seg_en_q   <= seg_en_d;
      sync_q     <= sync_d;
      ack_q      <= (state_d == RUN);
      busy_q     <= (state_d != IDLE);
      lock_err_q <= lock_err_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  assign seg_en       = seg_en_q;
  assign pll_sync_out = sync_q;
  assign ack          = ack_q;
  assign busy         = busy_q;
  assign lock_err     = lock_err_q;
  assign sync_cnt     = sync_cnt_q;

endmodule
